// File: rtl/rsa_dma_engine.sv
// rsa_dma_engine: responder side of the rsa core DMA handshake.
// Moves one DATA_W block as DATA_W/BUS_W single-word transactions on a
// valid/ready memory bus, one request outstanding at a time. Word k sits at
// base + k*(BUS_W/8) and occupies bits [k*BUS_W +: BUS_W] (word 0 = LSW).
module rsa_dma_engine #(
  parameter int DATA_W  = 1024,
  parameter int BUS_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dma_rx_start,
  input  logic [31:0]       dma_rx_address,
  output logic [DATA_W-1:0] dma_rx_data,
  input  logic              dma_tx_start,
  input  logic [31:0]       dma_tx_address,
  input  logic [DATA_W-1:0] dma_tx_data,
  output logic              dma_done,
  output logic              dma_idle,
  output logic              dma_error,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [31:0]       mem_req_addr,
  output logic [BUS_W-1:0]  mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [BUS_W-1:0]  mem_rsp_rdata,
  input  logic              mem_rsp_error
);

  localparam int BEATS = DATA_W / BUS_W;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int STEP  = BUS_W / 8;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, FIN} state_t;

  state_t            state;
  logic [KW-1:0]     beat;
  logic [KW-1:0]     beat_nx;
  logic [31:0]       base;
  logic [31:0]       start_addr;
  logic [TW-1:0]     tmo;
  logic [DATA_W-1:0] tx_buf;

  // rx has priority when both starts arrive together
  assign start_addr = dma_rx_start ? dma_rx_address : dma_tx_address;
  assign beat_nx    = beat + KW'(1);

  // Transfer sequencer: every output is a register updated here
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      beat          <= '0;
      base          <= '0;
      tmo           <= '0;
      tx_buf        <= '0;
      dma_rx_data   <= '0;
      dma_done      <= 1'b0;
      dma_idle      <= 1'b1;
      dma_error     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_rx_start || dma_tx_start) begin
            dma_idle      <= 1'b0;
            dma_error     <= 1'b0;
            beat          <= '0;
            base          <= start_addr;
            mem_req_write <= !dma_rx_start;
            // snapshot so the source may change while the write runs
            if (!dma_rx_start) tx_buf <= dma_tx_data;
            if (start_addr[1:0] != 2'b00) begin
              // misaligned block: abort without touching the bus
              dma_error <= 1'b1;
              dma_done  <= 1'b1;
              state     <= FIN;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= start_addr;
              mem_req_wdata <= dma_rx_start ? '0 : dma_tx_data[BUS_W-1:0];
              state         <= dma_rx_start ? RD_REQ : WR_REQ;
            end
          end
        end
        RD_REQ, WR_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            tmo           <= '0;
            state         <= (state == RD_REQ) ? RD_RSP : WR_RSP;
          end
        end
        RD_RSP, WR_RSP: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_error) begin
              dma_error <= 1'b1;
              dma_done  <= 1'b1;
              state     <= FIN;
            end else begin
              if (state == RD_RSP) dma_rx_data[beat*BUS_W +: BUS_W] <= mem_rsp_rdata;
              if (beat == KW'(BEATS - 1)) begin
                dma_done <= 1'b1;
                state    <= FIN;
              end else begin
                beat          <= beat_nx;
                mem_req_valid <= 1'b1;
                mem_req_addr  <= base + 32'(beat_nx) * 32'(STEP);
                if (state == WR_RSP) mem_req_wdata <= tx_buf[beat_nx*BUS_W +: BUS_W];
                state         <= (state == RD_RSP) ? RD_REQ : WR_REQ;
              end
            end
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            // memory never answered this beat; any late response lands outside *_RSP
            dma_error <= 1'b1;
            dma_done  <= 1'b1;
            state     <= FIN;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        FIN: begin
          dma_idle <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_dma_engine.sv
// Scoreboard bench for rsa_dma_engine: stimulus pushes expected bus requests
// and completions, a memory responder answers the bus, and a monitor pops and
// compares whenever the DUT accepts a request or pulses dma_done.
module tb_rsa_dma_engine;
  localparam int DATA_W  = 1024;
  localparam int BUS_W   = 32;
  localparam int BEATS   = 32;
  localparam int TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              dma_rx_start = 1'b0, dma_tx_start = 1'b0;
  logic [31:0]       dma_rx_address = '0, dma_tx_address = '0;
  logic [DATA_W-1:0] dma_rx_data;
  logic [DATA_W-1:0] dma_tx_data = '0;
  logic              dma_done, dma_idle, dma_error;
  logic              mem_req_valid, mem_req_write;
  logic              mem_req_ready = 1'b0;
  logic [31:0]       mem_req_addr;
  logic [BUS_W-1:0]  mem_req_wdata;
  logic              mem_rsp_valid = 1'b0, mem_rsp_error = 1'b0;
  logic [BUS_W-1:0]  mem_rsp_rdata = '0;

  always #5 clk = ~clk;

  rsa_dma_engine #(.DATA_W(DATA_W), .BUS_W(BUS_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .dma_rx_start(dma_rx_start), .dma_rx_address(dma_rx_address), .dma_rx_data(dma_rx_data),
    .dma_tx_start(dma_tx_start), .dma_tx_address(dma_tx_address), .dma_tx_data(dma_tx_data),
    .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_error(mem_rsp_error)
  );

  typedef struct packed {logic write; logic [31:0] addr; logic [31:0] wdata;} req_t;
  typedef struct {logic [DATA_W-1:0] rx; logic err;} cpl_t;

  req_t exp_req[$];
  cpl_t exp_cpl[$];
  int   n_cmp = 0, n_bad = 0;

  logic [31:0]       mem [0:4095];
  logic [DATA_W-1:0] model_rx = '0;

  // responder knobs, written only by the stimulus process
  int          err_beat = -1, drop_beat = -1, stall_beat = -1, stall_len = 0;
  int          stall_seq = 0, late_req = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] cur_base = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_blk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      for (int k = 0; k < BEATS; k++)
        if (act[k*32 +: 32] !== exp[k*32 +: 32]) begin
          $display("FAIL %s: word %0d got %h want %h", name, k, act[k*32 +: 32], exp[k*32 +: 32]);
          break;
        end
    end
  endtask

  task automatic fail_evt(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred, none required", name);
  endtask

  // ---------------- memory responder ----------------
  bit          pend = 1'b0, pend_wr = 1'b0;
  int          pend_beat = 0, stall_done = 0, stall_left = 0, late_done = 0;
  logic [31:0] pend_addr = '0, pend_wdata = '0;

  always @(negedge clk) begin
    int b;
    mem_rsp_valid = 1'b0;
    mem_rsp_error = 1'b0;
    if (!resetn) begin
      pend = 1'b0;
      stall_left = 0;
      mem_req_ready = 1'b0;
    end else begin
      if (late_done != late_req) begin
        late_done     = late_req;
        mem_rsp_valid = 1'b1;
        mem_rsp_error = 1'b1;
        mem_rsp_rdata = 32'hDEAD_BEEF;
      end else if (pend) begin
        pend          = 1'b0;
        mem_rsp_valid = 1'b1;
        if (pend_beat == err_beat) begin
          mem_rsp_error = 1'b1;
          mem_rsp_rdata = 32'hBAD0_0BAD;
        end else if (pend_wr) mem[pend_addr[13:2]] = pend_wdata;
        else mem_rsp_rdata = mem[pend_addr[13:2]];
      end
      b = int'((mem_req_addr - cur_base) >> 2);
      if (mem_req_valid && b == stall_beat && stall_done != stall_seq) begin
        stall_done = stall_seq;
        stall_left = stall_len;
      end
      if (stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_req_valid && mem_req_ready && b != drop_beat) begin
        pend       = 1'b1;
        pend_beat  = b;
        pend_wr    = mem_req_write;
        pend_addr  = mem_req_addr;
        pend_wdata = mem_req_wdata;
      end
    end
  end

  // ---------------- monitor ----------------
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  always @(negedge clk) begin
    req_t e;
    cpl_t c;
    #1;
    if (!resetn) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(mem_req_valid), 64'd1);
        chk("hold_addr", 64'(mem_req_addr), 64'(prev_addr));
        chk("hold_wdata", 64'(mem_req_wdata), 64'(prev_wdata));
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) fail_evt("unexpected_req");
        else begin
          e = exp_req.pop_front();
          chk("req_addr", 64'(mem_req_addr), 64'(e.addr));
          chk("req_write", 64'(mem_req_write), 64'(e.write));
          if (e.write) chk("req_wdata", 64'(mem_req_wdata), 64'(e.wdata));
        end
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;
      prev_wdata = mem_req_wdata;
      if (dma_done) begin
        if (exp_cpl.size() == 0) fail_evt("unexpected_done");
        else begin
          c = exp_cpl.pop_front();
          chk_blk("done_rx_data", dma_rx_data, c.rx);
          chk("done_error", 64'(dma_error), 64'(c.err));
          chk("done_idle_low", 64'(dma_idle), 64'd0);
        end
      end
    end
  end

  // ---------------- reference model (block-level) ----------------
  // stop < 0: all beats complete; otherwise beat 'stop' is issued but fails
  task automatic expect_read(logic [31:0] base, int stop, bit err);
    int n = (stop < 0) ? BEATS : stop + 1;
    int good = (stop < 0) ? BEATS : stop;
    cpl_t c;
    for (int k = 0; k < n; k++) exp_req.push_back('{1'b0, base + 32'(4*k), 32'h0});
    for (int k = 0; k < good; k++) model_rx[k*32 +: 32] = mem[(base + 32'(4*k)) >> 2];
    c.rx = model_rx;
    c.err = err;
    exp_cpl.push_back(c);
  endtask

  task automatic expect_write(logic [31:0] base, logic [DATA_W-1:0] td);
    cpl_t c;
    for (int k = 0; k < BEATS; k++) exp_req.push_back('{1'b1, base + 32'(4*k), td[k*32 +: 32]});
    c.rx = model_rx;
    c.err = 1'b0;
    exp_cpl.push_back(c);
  endtask

  task automatic go(bit rx, bit tx, logic [31:0] ra, logic [31:0] ta, logic [DATA_W-1:0] td);
    @(negedge clk);
    cur_base       = rx ? ra : ta;
    dma_rx_start   = rx;
    dma_tx_start   = tx;
    dma_rx_address = ra;
    dma_tx_address = ta;
    dma_tx_data    = td;
  endtask

  // cyc counts clock cycles with the start cycle as cycle 1
  task automatic wait_done(int bound, output int cyc);
    bit seen = 1'b0;
    cyc = 1;
    while (!seen && cyc < bound) begin
      @(negedge clk);
      dma_rx_start = 1'b0;
      dma_tx_start = 1'b0;
      dma_tx_data  = '1;
      #2;
      cyc++;
      if (dma_done) seen = 1'b1;
    end
    if (!seen) fail_evt("done_timeout");
    @(negedge clk);
    #2;
    chk("idle_after_done", 64'(dma_idle), 64'd1);
    chk("req_drained", 64'(exp_req.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [DATA_W-1:0] td;
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + 32'(i) - 32'd1024;

    // reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_idle", 64'(dma_idle), 64'd1);
    chk("rst_done", 64'(dma_done), 64'd0);
    chk("rst_error", 64'(dma_error), 64'd0);
    chk("rst_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_write", 64'(mem_req_write), 64'd0);
    chk("rst_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_wdata", 64'(mem_req_wdata), 64'd0);
    chk_blk("rst_rx_data", dma_rx_data, '0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // zero-wait read at 0x1000
    expect_read(32'h1000, -1, 1'b0);
    go(1'b1, 1'b0, 32'h1000, 32'h0, '0);
    wait_done(200, cyc);
    chk("read_latency", 64'(cyc), 64'd66);
    chk("read_w0", 64'(dma_rx_data[31:0]), 64'hA000_0000);
    chk("read_w31", 64'(dma_rx_data[1023:992]), 64'hA000_001F);

    // write with source changed after the start cycle
    for (int i = 0; i < BEATS; i++) td[i*32 +: 32] = 32'(i) * 32'h0101_0101;
    expect_write(32'h2000, td);
    go(1'b0, 1'b1, 32'h0, 32'h2000, td);
    wait_done(200, cyc);

    // backpressure on beat 3, reading back the written block
    stall_beat = 3;
    stall_len  = 5;
    stall_seq++;
    expect_read(32'h2000, -1, 1'b0);
    go(1'b1, 1'b0, 32'h2000, 32'h0, '0);
    wait_done(300, cyc);
    stall_beat = -1;
    chk("bp_w5", 64'(dma_rx_data[5*32 +: 32]), 64'h0505_0505);

    // bus error on beat 10
    err_beat = 10;
    expect_read(32'h1000, 10, 1'b1);
    go(1'b1, 1'b0, 32'h1000, 32'h0, '0);
    wait_done(200, cyc);
    err_beat = -1;

    // write after the error: error must clear
    for (int i = 0; i < BEATS; i++) td[i*32 +: 32] = $urandom;
    expect_write(32'h3000, td);
    go(1'b0, 1'b1, 32'h0, 32'h3000, td);
    wait_done(200, cyc);

    // no response on beat 4 -> timeout, then a stray late response
    drop_beat = 4;
    expect_read(32'h1100, 4, 1'b1);
    go(1'b1, 1'b0, 32'h1100, 32'h0, '0);
    wait_done(1300, cyc);
    chk("timeout_latency", 64'(cyc), 64'(2*4 + 1 + TIMEOUT + 2));
    drop_beat = -1;
    late_req++;
    repeat (3) @(negedge clk);
    #2;
    chk("late_error_held", 64'(dma_error), 64'd1);
    chk("late_idle", 64'(dma_idle), 64'd1);
    chk_blk("late_rx_held", dma_rx_data, model_rx);

    // rx and tx together: only the read happens
    expect_read(32'h1200, -1, 1'b0);
    go(1'b1, 1'b1, 32'h1200, 32'h3000, '1);
    wait_done(200, cyc);

    // misaligned base: no bus traffic
    begin
      cpl_t c;
      c.rx = model_rx;
      c.err = 1'b1;
      exp_cpl.push_back(c);
    end
    go(1'b1, 1'b0, 32'h1002, 32'h0, '0);
    wait_done(20, cyc);
    chk("unaligned_latency", 64'(cyc), 64'd2);

    // random traffic with random ready
    rand_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      a = 32'h1000 + (32'($urandom_range(0, 'h7C0)) << 2);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < BEATS; i++) td[i*32 +: 32] = $urandom;
        expect_write(a, td);
        go(1'b0, 1'b1, 32'h0, a, td);
      end else begin
        expect_read(a, -1, 1'b0);
        go(1'b1, 1'b0, a, 32'h0, '0);
      end
      wait_done(600, cyc);
    end
    rand_ready = 1'b0;

    // reset while beat 7 is being requested
    for (int k = 0; k < 8; k++) exp_req.push_back('{1'b0, 32'h1000 + 32'(4*k), 32'h0});
    go(1'b1, 1'b0, 32'h1000, 32'h0, '0);
    cyc = 0;
    do begin
      @(negedge clk);
      dma_rx_start = 1'b0;
      cyc++;
    end while (!(mem_req_valid && mem_req_addr == 32'h101C) && cyc < 100);
    if (cyc >= 100) fail_evt("beat7_timeout");
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_idle", 64'(dma_idle), 64'd1);
    chk("arst_valid", 64'(mem_req_valid), 64'd0);
    chk_blk("arst_rx_clear", dma_rx_data, '0);
    model_rx = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    chk("arst_idle_after", 64'(dma_idle), 64'd1);
    chk("arst_req_drained", 64'(exp_req.size()), 64'd0);
    chk("cpl_drained", 64'(exp_cpl.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
